// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage divider and HI/LO register pair.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

  // Iteration counter width: clog2 of the operand width, never narrower than 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_next_rem,
  output logic [WIDTH-1:0] o_next_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, i_divisor};

  // A clear MSB means the trial remainder is non-negative and the subtraction is kept.
  always_comb begin
    if (!w_trial[WIDTH]) begin
      o_next_rem = w_trial[WIDTH-1:0];
      o_next_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_next_rem = w_shifted[WIDTH-1:0];
      o_next_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider (one quotient bit per cycle) feeding the HI/LO pair, with MFHI/MFLO reads and stall request.
module divu_hilo_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_hi,
  input  logic             mf_lo,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       r_state,   w_state_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_done,    w_done_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [WIDTH-1:0] r_rem,     w_rem_nxt;
  logic [WIDTH-1:0] r_quo,     w_quo_nxt;
  logic [WIDTH-1:0] r_divisor, w_divisor_nxt;
  logic [WIDTH-1:0] r_hi,      w_hi_nxt;
  logic [WIDTH-1:0] r_lo,      w_lo_nxt;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .i_rem      (r_rem),
    .i_quo      (r_quo),
    .i_divisor  (r_divisor),
    .o_next_rem (w_step_rem),
    .o_next_quo (w_step_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divisor <= w_divisor_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  // A start that arrives while RUN is simply not looked at; stall_req makes the hazard unit reissue it.
  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divisor_nxt = r_divisor;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      IDLE: begin
        if (div_start) begin
          w_divisor_nxt = divisor;
          w_quo_nxt     = dividend;
          w_rem_nxt     = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
        w_rem_nxt = w_step_rem;
        w_quo_nxt = w_step_quo;
        w_cnt_nxt = r_cnt + 1'b1;
        // Final step goes straight into HI/LO so the result is readable in the done cycle.
        if (r_cnt == LAST_CNT) begin
          w_hi_nxt    = w_step_rem;
          w_lo_nxt    = w_step_quo;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign hilo_rdata = mf_hi ? r_hi : r_lo;
  assign stall_req  = r_busy & (div_start | mf_hi | mf_lo);

endmodule

// File: doc/divu_hilo_unit.md
Name: divu_hilo_unit

Overview:
- Multi-cycle unsigned divider plus HI/LO register pair in the EX stage.
- Consumes the DIV, Hi and Lo strobes and the RD1/RD2 operands issued by the ID/EX pipeline register.
- Executes DIVU by restoring division, one quotient bit per cycle, then writes HI = remainder and LO = quotient.
- Serves MFHI/MFLO reads and raises a stall request to the hazard unit while a division is in flight.

Parameters:
- WIDTH, 32, operand, quotient and remainder width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- div_start  input  1  DIVU issued in EX; sampled only on a rising edge.
- dividend  input  WIDTH  rs value (RD1 from ID/EX).
- divisor  input  WIDTH  rt value (RD2 from ID/EX).
- mf_hi  input  1  MFHI in EX (Hi from ID/EX).
- mf_lo  input  1  MFLO in EX (Lo from ID/EX).
- hilo_rdata  output  WIDTH  HI when mf_hi, else LO; combinational from the HI/LO registers.
- busy  output  1  division in progress (registered).
- done  output  1  one-cycle pulse; HI/LO were written at this edge.
- stall_req  output  1  busy & (div_start | mf_hi | mf_lo); combinational.

Behaviour:
- Reset: state IDLE, busy=0, done=0, HI=0, LO=0, iteration counter=0, internal remainder/quotient/divisor registers=0. Reset aborts any division in progress; HI/LO are not updated with partial results.
- States are IDLE and RUN.
- IDLE, on an edge with div_start=1:
  - latch divisor; quotient register <= dividend; remainder register <= 0; counter <= 0;
  - state -> RUN; busy=1 from the next cycle.
- IDLE, on an edge with div_start=0: no change; done <= 0.
- RUN, each edge performs one restoring step:
  - {rem,quo} shifted left by 1 into a (WIDTH+1)-bit trial remainder;
  - trial = shifted_rem - divisor, computed at WIDTH+1 bits;
  - if trial is non-negative (MSB=0): rem <= trial[WIDTH-1:0] and quotient LSB <= 1;
  - otherwise: rem <= shifted_rem and quotient LSB <= 0;
  - counter increments.
- RUN final step: on the edge where counter == WIDTH-1, the step result is written directly into HI (remainder) and LO (quotient). At that edge: done <= 1, busy <= 0, state -> IDLE.
- Latency: start sampled at edge E; steps occur at edges E+1 .. E+WIDTH. busy is high for WIDTH cycles. done and the new HI/LO are visible in the cycle after edge E+WIDTH.
- done is high for exactly one cycle.
- div_start while busy: ignored; no restart and no operand relatch. stall_req is high so the hazard unit holds the instruction; it is reissued once busy falls.
- Divide by zero: no special path. Restoring division naturally yields LO = all ones and HI = dividend. This behaviour is required and fixed.
- mf_hi and mf_lo both high: HI has priority. Neither high: hilo_rdata = LO.
- mf_hi or mf_lo while busy: stall_req=1 and hilo_rdata shows the old value; the consumer must not use it.
- mf_hi or mf_lo in the done cycle: stall_req=0 and hilo_rdata shows the new value.
- div_start in the done cycle (state IDLE): accepted, and a new division begins.
- HI/LO change only on a final step or on reset.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH default constant;
  - divider state enum {IDLE, RUN};
  - counter width = clog2(WIDTH).
- One sub-module, divu_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next_rem, next_quo.
  - Instantiated once inside divu_hilo_unit.

Test Plan:
- Basic division: div_start with dividend=100, divisor=7 -> busy high for 32 cycles; done pulses once; then mf_hi reads 2 and mf_lo reads 14.
- Maximum dividend: dividend=0xFFFFFFFF, divisor=1 -> LO=0xFFFFFFFF, HI=0.
- Dividend smaller than divisor: dividend=5, divisor=0x80000000 -> LO=0, HI=5.
- Divide by zero: dividend=5, divisor=0 -> LO=0xFFFFFFFF, HI=5; latency still 32 cycles.
- Interlock and ignored restart: start 100/7, then assert mf_lo at cycle 10 -> stall_req=1 until busy falls, and LO reads 14 afterwards. Assert div_start with 9/3 at cycle 5 -> ignored, HI/LO still 2/14. Reissue div_start in the done cycle -> accepted, and after 32 more cycles HI=0, LO=3.
- Reset mid-division: rst at cycle 16 of 100/7 -> next cycle busy=0, done=0, HI=LO=0. A following 9/3 yields HI=0, LO=3.
